pulse_stretcher: RTL and testbench

Converts single-cycle trigger pulses into held output levels of programmable length, the inverse of the edge-detection stage that derives one-cycle pulses from input levels. A trigger launches a high interval of `length_i` cycles. Triggers that arrive while the output is active are queued up to a fixed depth and replayed, separated by a programmable low gap, or they retrigger the active interval. Sits between pulse-producing control logic (edge detectors, FSM strobes) and level consumers (LEDs, enables, external strobes).

---
 rtl/pulse_pkg.sv | 11 +
 rtl/down_counter.sv | 28 ++
 rtl/pulse_stretcher.sv | 150 +++++++++++++++
 tb/tb_pulse_stretcher.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types for the pulse stretcher: the FSM state encoding used by the top
// and exposed on its debug state output.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter shared by the HIGH and GAP phases; holds at zero
// rather than wrapping so an idle counter stays quiet.
module down_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [CNT_BITS-1:0] i_load_val,
  input  logic                i_dec,
  output logic                o_zero
);

  logic [CNT_BITS-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_BITS'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into high intervals of length_i cycles, queuing
// (or retriggering on) triggers that arrive while an interval or gap is running.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int CNT_BITS    = 16,
  parameter int MAX_PENDING = 3,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             enable_i,
  input  logic                             trigger_i,
  input  logic [CNT_BITS-1:0]              length_i,
  input  logic [CNT_BITS-1:0]              gap_i,
  output logic                             level_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             dropped_o,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_o,
  output logic [1:0]                       state_o
);

  localparam int PEND_BITS = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX = PEND_BITS'(MAX_PENDING);

  pulse_state_t         r_state;
  pulse_state_t         w_state_nx;
  logic [PEND_BITS-1:0] r_pending;
  logic [PEND_BITS-1:0] w_pending_nx;
  logic                 w_cnt_zero;
  logic                 w_cnt_clr;
  logic                 w_cnt_load;
  logic                 w_cnt_dec;
  logic [CNT_BITS-1:0]  w_cnt_val;
  logic [CNT_BITS-1:0]  w_len_load;
  logic [CNT_BITS-1:0]  w_gap_load;
  logic                 w_len_ok;
  logic                 w_retrig;
  logic                 w_deq;
  logic                 w_queue_trig;
  logic                 w_done;
  logic                 w_drop;

  assign w_cnt_clr = reset_i || !enable_i;

  down_counter #(.CNT_BITS(CNT_BITS)) u_counter (
    .i_clk      (clock_i),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_len_ok     = (length_i != '0);
    w_len_load   = length_i - CNT_BITS'(1);
    w_gap_load   = (gap_i == '0) ? '0 : gap_i - CNT_BITS'(1);
    w_retrig     = RETRIGGER && (r_state == HIGH) && trigger_i && w_len_ok;
    w_deq        = (r_state == GAP) && w_cnt_zero;
    w_queue_trig = trigger_i && (r_state != IDLE) && !w_retrig;

    // A trigger landing on a dequeue takes the freed slot, so it is never dropped.
    w_drop       = 1'b0;
    w_pending_nx = r_pending;
    if (w_deq && !w_queue_trig) begin
      w_pending_nx = r_pending - PEND_BITS'(1);
    end else if (w_queue_trig && !w_deq) begin
      if (r_pending == PEND_MAX) w_drop = 1'b1;
      else                       w_pending_nx = r_pending + PEND_BITS'(1);
    end

    w_state_nx = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = w_len_load;
    w_cnt_dec  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (trigger_i) begin
          if (w_len_ok) begin
            w_state_nx = HIGH;
            w_cnt_load = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      HIGH: begin
        if (w_retrig) begin
          w_cnt_load = 1'b1;
        end else if (w_cnt_zero) begin
          w_done = 1'b1;
          if (w_pending_nx != '0) begin
            w_state_nx = GAP;
            w_cnt_load = 1'b1;
            w_cnt_val  = w_gap_load;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          if (w_len_ok) begin
            w_state_nx = HIGH;
            w_cnt_load = 1'b1;
          end else begin
            // Zero-length entry is consumed; restart the gap if more remain.
            w_drop = 1'b1;
            if (w_pending_nx != '0) begin
              w_cnt_load = 1'b1;
              w_cnt_val  = w_gap_load;
            end else begin
              w_state_nx = IDLE;
            end
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || !enable_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
      level_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      dropped_o <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pending <= w_pending_nx;
      level_o   <= (w_state_nx == HIGH);
      busy_o    <= (w_state_nx != IDLE);
      done_o    <= w_done;
      dropped_o <= w_drop;
    end
  end

  assign pending_o = r_pending;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed vector table, corner-case sequences and
// randomized traffic, all scored against a remaining-cycles reference model.
module tb_pulse_stretcher;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b1;
  logic        en   = 1'b1;
  logic        trig = 1'b0;
  logic [15:0] len  = 16'd0;
  logic [15:0] gap  = 16'd0;

  logic       lvl0, busy0, done0, drop0;
  logic [1:0] pend0, st0;
  logic       lvl1, busy1, done1, drop1;
  logic       pend1;
  logic [1:0] st1;

  pulse_stretcher #(.CNT_BITS(16), .MAX_PENDING(3), .RETRIGGER(1'b0)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .trigger_i(trig),
    .length_i(len), .gap_i(gap), .level_o(lvl0), .busy_o(busy0),
    .done_o(done0), .dropped_o(drop0), .pending_o(pend0), .state_o(st0)
  );

  pulse_stretcher #(.CNT_BITS(16), .MAX_PENDING(1), .RETRIGGER(1'b1)) dut_rt (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .trigger_i(trig),
    .length_i(len), .gap_i(gap), .level_o(lvl1), .busy_o(busy1),
    .done_o(done1), .dropped_o(drop1), .pending_o(pend1), .state_o(st1)
  );

  // ---------------- reference model ----------------
  // hi = high cycles still to come, gp = gap cycles still to come, q = queued.
  typedef struct {
    int hi;
    int gp;
    int q;
    bit done;
    bit drop;
  } model_t;

  model_t m0 = '{0, 0, 0, 1'b0, 1'b0};
  model_t m1 = '{0, 0, 0, 1'b0, 1'b0};

  task automatic model_step(inout model_t m, input bit rt, input int maxp);
    int qn;
    bit retrig;
    int g1;
    m.done = 1'b0;
    m.drop = 1'b0;
    g1 = (gap == 16'd0) ? 1 : int'(gap);
    if (rst || !en) begin
      m.hi = 0; m.gp = 0; m.q = 0;
    end else if (m.hi == 0 && m.gp == 0) begin
      if (trig) begin
        if (len != 16'd0) m.hi = int'(len);
        else              m.drop = 1'b1;
      end
    end else begin
      retrig = rt && (m.hi > 0) && trig && (len != 16'd0);
      qn = m.q;
      if (m.gp == 1) qn--;
      if (trig && !retrig) begin
        if (m.gp == 1 || m.q < maxp) qn++;
        else                         m.drop = 1'b1;
      end
      if (m.hi > 0) begin
        if (retrig) m.hi = int'(len);
        else if (m.hi == 1) begin
          m.done = 1'b1;
          m.hi   = 0;
          m.gp   = (qn > 0) ? g1 : 0;
        end else m.hi--;
      end else if (m.gp == 1) begin
        m.gp = 0;
        if (len != 16'd0) m.hi = int'(len);
        else begin
          m.drop = 1'b1;
          m.gp   = (qn > 0) ? g1 : 0;
        end
      end else m.gp--;
      m.q = qn;
    end
  endtask

  function automatic logic [5:0] pack(input model_t m);
    return {m.hi > 0, (m.hi > 0) || (m.gp > 0), m.done, m.drop, 2'(m.q)};
  endfunction

  function automatic logic [5:0] out0();
    return {lvl0, busy0, done0, drop0, pend0};
  endfunction

  function automatic logic [5:0] out1();
    return {lvl1, busy1, done1, drop1, 1'b0, pend1};
  endfunction

  // ---------------- scoreboard ----------------
  logic [5:0] exp0_q[$];
  logic [5:0] exp1_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic t,
                       input logic [15:0] l, input logic [15:0] g);
    rst = r; en = e; trig = t; len = l; gap = g;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(m0, 1'b0, 3);
    exp0_q.push_back(pack(m0));
    model_step(m1, 1'b1, 1);
    exp1_q.push_back(pack(m1));
    #1;
    cyc++;
    check("sb_dut", out0(), exp0_q.pop_front());
    check("sb_dut_rt", out1(), exp1_q.pop_front());
  endtask

  // Directed vectors: inputs for one cycle, dut outputs expected after that edge.
  // exp = {level, busy, done, dropped, pending[1:0]}
  typedef struct {
    logic        trig;
    logic [15:0] len;
    logic [15:0] gap;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic [15:0] l, input logic [15:0] g,
                     input logic [5:0] e);
    vec_t v;
    v.trig = t; v.len = l; v.gap = g; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // single pulse, L=4
    add(1'b1, 16'd4, 16'd0, 6'b110000);
    add(1'b0, 16'd4, 16'd0, 6'b110000);
    add(1'b0, 16'd4, 16'd0, 6'b110000);
    add(1'b0, 16'd4, 16'd0, 6'b110000);
    add(1'b0, 16'd4, 16'd0, 6'b001000);
    add(1'b0, 16'd4, 16'd0, 6'b000000);
    // zero length in IDLE
    add(1'b1, 16'd0, 16'd0, 6'b000100);
    add(1'b0, 16'd0, 16'd0, 6'b000000);
    // queueing, L=3 G=2, triggers at t, t+2, t+3
    add(1'b1, 16'd3, 16'd2, 6'b110000);
    add(1'b0, 16'd3, 16'd2, 6'b110000);
    add(1'b1, 16'd3, 16'd2, 6'b110001);
    add(1'b1, 16'd3, 16'd2, 6'b011010);
    add(1'b0, 16'd3, 16'd2, 6'b010010);
    add(1'b0, 16'd3, 16'd2, 6'b110001);
    add(1'b0, 16'd3, 16'd2, 6'b110001);
    add(1'b0, 16'd3, 16'd2, 6'b110001);
    add(1'b0, 16'd3, 16'd2, 6'b011001);
    add(1'b0, 16'd3, 16'd2, 6'b010001);
    add(1'b0, 16'd3, 16'd2, 6'b110000);
    add(1'b0, 16'd3, 16'd2, 6'b110000);
    add(1'b0, 16'd3, 16'd2, 6'b110000);
    add(1'b0, 16'd3, 16'd2, 6'b001000);
    add(1'b0, 16'd3, 16'd2, 6'b000000);
    // gap_i=0 gives exactly one low cycle between queued pulses, L=2
    add(1'b1, 16'd2, 16'd0, 6'b110000);
    add(1'b1, 16'd2, 16'd0, 6'b110001);
    add(1'b0, 16'd2, 16'd0, 6'b011001);
    add(1'b0, 16'd2, 16'd0, 6'b110000);
    add(1'b0, 16'd2, 16'd0, 6'b110000);
    add(1'b0, 16'd2, 16'd0, 6'b001000);
    add(1'b0, 16'd2, 16'd0, 6'b000000);

    // reset state
    drive(1'b1, 1'b1, 1'b0, 16'd4, 16'd0);
    tick();
    check("reset_outs", out0(), 6'd0);
    check("reset_state", {4'd0, st0}, 6'd0);
    drive(1'b0, 1'b1, 1'b0, 16'd4, 16'd0);
    tick();
    check("idle_outs", out0(), 6'd0);

    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].trig, vecs[i].len, vecs[i].gap);
      tick();
      check($sformatf("vec%0d", i), out0(), vecs[i].exp);
    end

    // overflow: L=20, triggers on six consecutive cycles
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'd20, 16'd1);
      tick();
      check("ovf_pend", {4'd0, pend0}, 6'((i < 3) ? i : 3));
      check("ovf_drop", {5'd0, drop0}, 6'(i >= 4));
    end
    drive(1'b0, 1'b1, 1'b0, 16'd20, 16'd1);
    tick();
    check("ovf_after", out0(), 6'b110011);
    // disable with a full queue; trigger while disabled is ignored
    drive(1'b0, 1'b0, 1'b1, 16'd20, 16'd1);
    tick();
    check("dis_clear", out0(), 6'd0);
    drive(1'b0, 1'b0, 1'b0, 16'd20, 16'd1);
    tick();
    check("dis_hold", out0(), 6'd0);

    // abort: L=10, trigger at t, enable low at t+4
    drive(1'b0, 1'b1, 1'b1, 16'd10, 16'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'd10, 16'd1);
      tick();
    end
    check("abort_pre", out0(), 6'b110000);
    drive(1'b0, 1'b0, 1'b0, 16'd10, 16'd1);
    tick();
    check("abort_cut", out0(), 6'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'd10, 16'd1);
      tick();
      check("abort_quiet", out0(), 6'd0);
    end

    // reset asserted mid-GAP: L=2 G=5
    drive(1'b0, 1'b1, 1'b1, 16'd2, 16'd5);
    tick();
    tick();
    drive(1'b0, 1'b1, 1'b0, 16'd2, 16'd5);
    tick();
    check("gap_enter", out0(), 6'b011001);
    tick();
    check("gap_pre", out0(), 6'b010001);
    drive(1'b1, 1'b1, 1'b0, 16'd2, 16'd5);
    tick();
    check("gap_reset", out0(), 6'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'd2, 16'd5);
      tick();
      check("gap_quiet", out0(), 6'd0);
    end

    // retrigger on dut_rt: L=5, triggers at t and t+3
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, (i == 0) || (i == 3), 16'd5, 16'd1);
      tick();
      check("rt_level", {5'd0, lvl1}, 6'(i <= 7));
      check("rt_done", {5'd0, done1}, 6'(i == 8));
      check("rt_pend", {5'd0, pend1}, 6'd0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0,
            $urandom_range(0, 2) == 0, 16'($urandom_range(0, 6)),
            16'($urandom_range(0, 4)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
